// File: rtl/noise_pkg.sv
// Shared types and table geometry for the noise generator and its CDF table loader.
package noise_pkg;

    localparam int unsigned NOISE_TABLE_ENTRIES = 128;
    localparam int unsigned NOISE_DATA_W        = 64;
    localparam int unsigned NOISE_IDX_W         = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StWaitDone,
        StReady,
        StError
    } loader_state_e;

endpackage

// File: rtl/noise_cdf_loader_if.sv
// PDF input stream, table-write bus and status lines between the CDF loader and its neighbours.
// master: the loader itself; slave: host/config path plus noise generator.
interface noise_cdf_loader_if
    import noise_pkg::*;
#(
    parameter int unsigned DATA_W = NOISE_DATA_W,
    parameter int unsigned IDX_W  = NOISE_IDX_W
);
    logic              start;
    logic [DATA_W-1:0] pdf_data;
    logic              pdf_valid;
    logic              pdf_ready;
    logic [DATA_W-1:0] mem_data;
    logic [IDX_W-1:0]  location;
    logic              load_mem;
    logic              done_wait;
    logic              busy;
    logic              table_ready;
    logic              error;
    logic              overflow;

    modport master (
        input  start, pdf_data, pdf_valid, done_wait,
        output pdf_ready, mem_data, location, load_mem, busy, table_ready, error, overflow
    );

    modport slave (
        output start, pdf_data, pdf_valid, done_wait,
        input  pdf_ready, mem_data, location, load_mem, busy, table_ready, error, overflow
    );

endinterface

// File: rtl/cdf_sat_accum.sv
// Saturating accumulator: sum clamps at all-ones on carry-out and a sticky overflow flag records
// that it happened. clr_i has priority over en_i.
module cdf_sat_accum #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              ovf_o
);

    logic [DATA_W-1:0] sum_q, sum_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W:0]   add;

    // Next sum: one-bit-wider add, carry means saturate.
    always_comb begin
        add   = {1'b0, sum_q} + {1'b0, data_i};
        sum_d = sum_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            sum_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            sum_d = add[DATA_W] ? '1 : add[DATA_W-1:0];
            ovf_d = ovf_q | add[DATA_W];
        end
    end

    // Accumulator state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum_o = sum_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/noise_cdf_loader.sv
// Builds the noise generator's CDF table from a PDF weight stream and writes it via load_mem.
// Optional build macro CDF_FORCE_FULL_SCALE_EN: forces the last table entry to all-ones.
module noise_cdf_loader
    import noise_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES  = NOISE_TABLE_ENTRIES,
    parameter int unsigned DATA_W       = NOISE_DATA_W,
    parameter int unsigned IDX_W        = NOISE_IDX_W,
    parameter int unsigned FLUSH_BEATS  = 2,
    parameter int unsigned DONE_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    noise_cdf_loader_if.master bus
);

    localparam int unsigned FlushW = (FLUSH_BEATS > 0) ? $clog2(FLUSH_BEATS + 1) : 1;
    localparam int unsigned TmoW   = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0]  LastIdx   = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH_BEATS);
    localparam logic [TmoW-1:0]   TmoLast   = TmoW'(DONE_TIMEOUT - 1);

    loader_state_e     state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  loc_q, loc_d;
    logic              load_q, load_d;
    logic [FlushW-1:0] flush_q, flush_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              accept;
    logic              clr;
    logic [DATA_W-1:0] sum;
    logic              ovf;

    // Running CDF; its register output doubles as mem_data, giving the 1-cycle write latency.
    cdf_sat_accum #(
        .DATA_W (DATA_W)
    ) u_accum (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (clr),
        .en_i   (accept),
        .data_i (bus.pdf_data),
        .sum_o  (sum),
        .ovf_o  (ovf)
    );

    // Next-state and counter control. FLUSH starts on the cycle the last entry is written and
    // adds FLUSH_BEATS further strobes before WAIT_DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loc_d   = loc_q;
        load_d  = 1'b0;
        flush_d = flush_q;
        tmo_d   = tmo_q;
        accept  = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            StIdle, StReady, StError: begin
                if (bus.start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    loc_d   = '0;
                    clr     = 1'b1;
                end
            end
            StLoad: begin
                accept = bus.pdf_valid;
                if (accept) begin
                    load_d = 1'b1;
                    loc_d  = cnt_q;
                    if (cnt_q == LastIdx) begin
                        state_d = StFlush;
                        flush_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFlush: begin
                if (flush_q == FlushLast) begin
                    state_d = StWaitDone;
                    tmo_d   = '0;
                end else begin
                    load_d  = 1'b1;
                    flush_d = flush_q + 1'b1;
                end
            end
            StWaitDone: begin
                // done_wait takes priority over the timeout on the same cycle.
                if (bus.done_wait) begin
                    state_d = StReady;
                end else if (tmo_q == TmoLast) begin
                    state_d = StError;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers; reset aborts any load in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            loc_q   <= '0;
            load_q  <= 1'b0;
            flush_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loc_q   <= loc_d;
            load_q  <= load_d;
            flush_q <= flush_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef CDF_FORCE_FULL_SCALE_EN
    // Last bin reads full scale so every uniform sample lands in some bin.
    assign bus.mem_data = (loc_q == LastIdx) ? '1 : sum;
`else
    assign bus.mem_data = sum;
`endif

    assign bus.location    = loc_q;
    assign bus.load_mem    = load_q;
    assign bus.overflow    = ovf;
    assign bus.pdf_ready   = (state_q == StLoad);
    assign bus.busy        = (state_q == StLoad) || (state_q == StFlush) ||
                             (state_q == StWaitDone);
    assign bus.table_ready = (state_q == StReady);
    assign bus.error       = (state_q == StError);

endmodule

// File: tb/tb_noise_cdf_loader.sv
// Self-checking bench for noise_cdf_loader: randomized streams against a CDF reference model.
module tb_noise_cdf_loader;
    import noise_pkg::*;

    localparam int N   = 128;
    localparam int FB  = 2;
    localparam int TMO = 1024;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    noise_cdf_loader_if #(.DATA_W(64), .IDX_W(8)) bus ();

    noise_cdf_loader #(
        .NUM_ENTRIES  (N),
        .DATA_W       (64),
        .IDX_W        (8),
        .FLUSH_BEATS  (FB),
        .DONE_TIMEOUT (TMO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_wr_cyc = 0;

    logic [63:0] w       [N];
    logic [63:0] exp_cdf [N];
    bit          exp_ovf;
    logic [7:0]  obs_loc [$];
    logic [63:0] obs_dat [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe seen on the table bus.
    always @(negedge clk) begin
        if (bus.load_mem === 1'b1) begin
            obs_loc.push_back(bus.location);
            obs_dat.push_back(bus.mem_data);
            last_wr_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Reference: CDF as running sum clamped to the 64-bit maximum.
    task automatic build_exp();
        logic [63:0] acc;
        acc     = '0;
        exp_ovf = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (w[k] > ~acc) begin
                acc     = '1;
                exp_ovf = 1'b1;
            end else begin
                acc = acc + w[k];
            end
            exp_cdf[k] = acc;
        end
`ifdef CDF_FORCE_FULL_SCALE_EN
        exp_cdf[N-1] = '1;
`endif
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_load_mem"}, bus.load_mem, 0);
        chk({tag, "_mem_data"}, bus.mem_data, 0);
        chk({tag, "_location"}, bus.location, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_table_ready"}, bus.table_ready, 0);
        chk({tag, "_error"}, bus.error, 0);
        chk({tag, "_overflow"}, bus.overflow, 0);
        chk({tag, "_pdf_ready"}, bus.pdf_ready, 0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // mode 0: no bubbles, 1: valid every other cycle, 2: random bubbles.
    task automatic drive_stream(input int mode, input int nbeats, input bit noise_start);
        int k;
        int c;
        bit v;
        bit acc;
        k = 0;
        c = 0;
        while (k < nbeats && c < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.pdf_valid = v;
            bus.pdf_data  = v ? w[k] : {$urandom, $urandom};
            bus.start     = noise_start && ($urandom_range(0, 7) == 0);
            acc = v && bus.pdf_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            c++;
        end
        bus.pdf_valid = 1'b0;
        bus.start     = 1'b0;
        chk("beats_accepted", k, nbeats);
    endtask

    task automatic wait_writes(input int n);
        int c;
        c = 0;
        while (obs_loc.size() < n && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("writes_reached", obs_loc.size(), n);
    endtask

    task automatic run_load(input int mode, input bit noise_start, input logic done_val);
        int idx;
        build_exp();
        obs_loc.delete();
        obs_dat.delete();
        bus.done_wait = done_val;
        pulse_start();
        chk("busy_in_load", bus.busy, 1);
        chk("overflow_cleared", bus.overflow, 0);
        drive_stream(mode, N, noise_start);
        wait_writes(N + FB);
        repeat (3) @(negedge clk);
        chk("write_count", obs_loc.size(), N + FB);
        for (int i = 0; i < obs_loc.size() && i < N + FB; i++) begin
            idx = (i < N) ? i : N - 1;
            chk($sformatf("loc%0d", i), obs_loc[i], idx);
            chk($sformatf("data%0d", i), obs_dat[i], exp_cdf[idx]);
        end
        chk("overflow", bus.overflow, exp_ovf);
    endtask

    task automatic expect_ready(input string tag);
        chk({tag, "_table_ready"}, bus.table_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_error"}, bus.error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int err_cyc;
        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.pdf_valid = 1'b0;
        bus.pdf_data  = '0;
        bus.done_wait = 1'b0;
        #12;
        check_idle("reset");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Equal weights, no bubbles; last bin saturates to all-ones.
        for (int k = 0; k < N; k++) w[k] = 64'h0200_0000_0000_0000;
        run_load(0, 1'b0, 1'b1);
        expect_ready("c1");

        // Same stream with bubbles; done_wait already high on entry to LOAD.
        run_load(1, 1'b0, 1'b1);
        expect_ready("c2");

        // Sparse weights forcing saturation at bin 11.
        for (int k = 0; k < N; k++) w[k] = '0;
        w[10] = 64'hFFFF_FFFF_FFFF_FFF0;
        w[11] = 64'h20;
        run_load(2, 1'b0, 1'b1);
        expect_ready("c3");

        // Timeout: done_wait held low after flush.
        run_load(0, 1'b0, 1'b0);
        c = 0;
        while (!bus.error && c < TMO + 100) begin
            @(negedge clk);
            c++;
        end
        err_cyc = cyc;
        chk("error_raised", bus.error, 1);
        chk("timeout_cycles", err_cyc - last_wr_cyc, TMO + 1);
        chk("timeout_busy", bus.busy, 0);
        chk("timeout_table_ready", bus.table_ready, 0);
        pulse_start();
        chk("restart_overflow", bus.overflow, 0);
        chk("restart_error", bus.error, 0);
        chk("restart_busy", bus.busy, 1);

        // Abort the restarted load with reset after beat 50.
        for (int k = 0; k < N; k++) w[k] = {$urandom, $urandom} >> 8;
        drive_stream(2, 51, 1'b0);
        rstn = 1'b0;
        #2;
        check_idle("midreset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < N; k++) w[k] = {$urandom, $urandom} >> 8;
        run_load(2, 1'b0, 1'b1);
        expect_ready("c5");

        // start pulses during LOAD and WAIT_DONE must be ignored.
        for (int k = 0; k < N; k++) w[k] = {$urandom, $urandom} >> 7;
        run_load(2, 1'b1, 1'b0);
        chk("wait_busy", bus.busy, 1);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("wait_start_busy", bus.busy, 1);
        chk("wait_start_table_ready", bus.table_ready, 0);
        chk("wait_start_no_writes", obs_loc.size(), N + FB);
        bus.done_wait = 1'b1;
        repeat (2) @(negedge clk);
        expect_ready("c6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
